// File: rtl/game_countdown.sv
// Round timer for the whack-a-mole game: loadable countdown with
// start/pause/resume, saturating bonus time, low-time warning, a one-cycle
// expiry pulse and BCD digits for the 7-segment display path.
module game_countdown #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned START_VAL   = 60,
    parameter int unsigned MAX_VAL     = 99,
    parameter int unsigned TICK_CYCLES = 100,
    parameter int unsigned WARN_THRESH = 10,
    parameter int unsigned BONUS       = 5
) (
    input  logic             clk_o,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             add_time,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             expired,
    output logic             warn,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);

    // Prescaler width; a single-cycle tick still needs one (constant) bit.
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] WARN_W  = WIDTH'(WARN_THRESH);
    localparam logic [WIDTH-1:0] TEN_W   = WIDTH'(10);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   BONUS_X = (WIDTH+1)'(BONUS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nxt;
    logic             expired_nxt;
    logic             tick_c;

    // Load value mapping: zero selects the default round length, large values clamp.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        if (v == '0) begin
            return START_W;
        end else if (v > MAX_W) begin
            return MAX_W;
        end
        return v;
    endfunction

    // count + bonus - tick, one bit wider than count, clamped to [0, MAX_VAL].
    function automatic logic [WIDTH-1:0] adjust(input logic [WIDTH-1:0] c,
                                                input logic             add,
                                                input logic             dec);
        logic [WIDTH:0] up;
        up = {1'b0, c} + (add ? BONUS_X : '0);
        if (dec) begin
            up = (up == '0) ? '0 : up - (WIDTH+1)'(1);
        end
        if (up > MAX_X) begin
            up = MAX_X;
        end
        return up[WIDTH-1:0];
    endfunction

    // Tick fires when the running prescaler sits at its terminal value.
    assign tick_c = (state == ST_RUN) && (presc == PS_LAST);

    // Next-state, next-count and prescaler logic; load overrides everything.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        presc_nxt   = presc;
        expired_nxt = 1'b0;
        if (load) begin
            state_nxt = ST_IDLE;
            count_nxt = sat_load(load_val);
            presc_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                        presc_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // Prescaler is held so resume continues the partial step.
                        state_nxt = ST_PAUSED;
                        count_nxt = adjust(count, add_time, 1'b0);
                    end else begin
                        presc_nxt = tick_c ? '0 : presc + PW'(1);
                        count_nxt = adjust(count, add_time, tick_c);
                        if (count_nxt == '0) begin
                            state_nxt   = ST_DONE;
                            expired_nxt = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    count_nxt = adjust(count, add_time, 1'b0);
                    if (pause || start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_nxt = '0;
                    if (start) begin
                        state_nxt = ST_RUN;
                        count_nxt = START_W;
                        presc_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and expiry pulse registers.
    always_ff @(posedge clk_o) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= START_W;
            presc   <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            presc   <= presc_nxt;
            expired <= expired_nxt;
        end
    end

    assign running  = (state == ST_RUN);
    assign paused   = (state == ST_PAUSED);
    assign done     = (state == ST_DONE);
    assign warn     = (running || paused) && (count != '0) && (count <= WARN_W);
    assign bcd_tens = 4'(count / TEN_W);
    assign bcd_ones = 4'(count % TEN_W);

endmodule
